// File: rtl/sixteen_bit_seq_subtractor.sv
// Multi-cycle 16-bit subtractor that computes one byte per cycle (low, then high)
// and presents the result with flags behind a valid/ready handshake.
module sixteen_bit_seq_subtractor (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] A,
  input  logic [15:0] B,
  input  logic        Bin,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] Diff,
  output logic        Bout,
  output logic        Z,
  output logic        N,
  output logic        V
);

  typedef enum logic [1:0] {IDLE, LO, HI, DONE} state_t;

  typedef struct packed {
    logic [15:0] a;
    logic [15:0] b;
    logic        bin;
  } opnd_t;

  state_t      state, state_nxt;
  opnd_t       opnd;
  logic        borrow_q;
  logic [15:0] diff_q;
  logic        bout_q, z_q, n_q, v_q, out_valid_q;
  logic [8:0]  lo_sub, hi_sub;

  // Bit 8 of each 9-bit difference is the byte's borrow-out.
  assign lo_sub = {1'b0, opnd.a[7:0]}  - {1'b0, opnd.b[7:0]}  - {8'd0, opnd.bin};
  assign hi_sub = {1'b0, opnd.a[15:8]} - {1'b0, opnd.b[15:8]} - {8'd0, borrow_q};

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid)  state_nxt = LO;
      LO:                     state_nxt = HI;
      HI:                     state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default:                state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      opnd        <= '0;
      borrow_q    <= 1'b0;
      diff_q      <= '0;
      bout_q      <= 1'b0;
      z_q         <= 1'b0;
      n_q         <= 1'b0;
      v_q         <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid) opnd <= {A, B, Bin};
        LO: begin
          diff_q[7:0] <= lo_sub[7:0];
          borrow_q    <= lo_sub[8];
        end
        HI: begin
          diff_q[15:8] <= hi_sub[7:0];
          bout_q       <= hi_sub[8];
          z_q          <= ({hi_sub[7:0], diff_q[7:0]} == 16'h0000);
          n_q          <= hi_sub[7];
          v_q          <= (opnd.a[15] != opnd.b[15]) && (hi_sub[7] != opnd.a[15]);
          out_valid_q  <= 1'b1;
        end
        DONE: if (out_ready) out_valid_q <= 1'b0;
        default: ;
      endcase
    end
  end

  // Gated by rst_n so the upstream sees not-ready for the whole reset cycle.
  assign in_ready  = (state == IDLE) && rst_n;
  assign out_valid = out_valid_q;
  assign Diff      = diff_q;
  assign Bout      = bout_q;
  assign Z         = z_q;
  assign N         = n_q;
  assign V         = v_q;

endmodule

// File: tb/tb_sixteen_bit_seq_subtractor.sv
// Directed self-checking bench for sixteen_bit_seq_subtractor.
module tb_sixteen_bit_seq_subtractor;

  logic        clk = 1'b0;
  logic        rst_n, in_valid, in_ready, Bin, out_valid, out_ready;
  logic [15:0] A, B, Diff;
  logic        Bout, Z, N, V;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  sixteen_bit_seq_subtractor dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .Bin(Bin), .out_valid(out_valid), .out_ready(out_ready),
    .Diff(Diff), .Bout(Bout), .Z(Z), .N(N), .V(V)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    A = 16'h0; B = 16'h0; Bin = 1'b0;
    step(); step();
    n_cmp++;
    if (in_ready !== 1'b0) begin n_err++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
    n_cmp++;
    if ({out_valid, Diff, Bout, Z, N, V} !== 21'd0) begin
      n_err++; $display("FAIL reset_outputs: got ov=%b diff=%h flags=%b%b%b%b want all 0", out_valid, Diff, Bout, Z, N, V);
    end
    rst_n = 1'b1;
    #1;
    n_cmp++;
    if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_release_ready: got %b want 1", in_ready); end
  endtask

  task automatic test_arith();
    logic [15:0] va[8], vb[8], vd[8];
    logic        vbin[8];
    logic [3:0]  vf[8];  // {Bout, Z, N, V}
    va   = '{16'h1234, 16'h0000, 16'h8000, 16'h0100, 16'h5555, 16'h0000, 16'h00FF, 16'h7FFF};
    vb   = '{16'h0234, 16'h0001, 16'h0001, 16'h0001, 16'h5554, 16'hFFFF, 16'h00FF, 16'hFFFF};
    vbin = '{1'b0,     1'b0,     1'b0,     1'b1,     1'b1,     1'b1,     1'b1,     1'b0};
    vd   = '{16'h1000, 16'hFFFF, 16'h7FFF, 16'h00FE, 16'h0000, 16'h0000, 16'hFFFF, 16'h8000};
    vf   = '{4'b0000,  4'b1010,  4'b0001,  4'b0000,  4'b0100,  4'b1100,  4'b1010,  4'b1011};
    for (int i = 0; i < 8; i++) begin
      A = va[i]; B = vb[i]; Bin = vbin[i]; in_valid = 1'b1; out_ready = 1'b0;
      n_cmp++;
      if (in_ready !== 1'b1) begin n_err++; $display("FAIL arith%0d_ready: got %b want 1", i, in_ready); end
      step();                               // accept edge k
      in_valid = 1'b0;
      A = ~va[i]; B = va[i]; Bin = ~vbin[i]; // scramble inputs after acceptance
      n_cmp++;
      if (out_valid !== 1'b0) begin n_err++; $display("FAIL arith%0d_lat1: got ov=%b want 0", i, out_valid); end
      step();                               // k+1
      n_cmp++;
      if (out_valid !== 1'b0) begin n_err++; $display("FAIL arith%0d_lat2: got ov=%b want 0", i, out_valid); end
      step();                               // k+2
      n_cmp++;
      if ({out_valid, Diff, Bout, Z, N, V} !== {1'b1, vd[i], vf[i]}) begin
        n_err++; $display("FAIL arith%0d_result: got ov=%b diff=%h bznv=%b%b%b%b want ov=1 diff=%h bznv=%b",
                          i, out_valid, Diff, Bout, Z, N, V, vd[i], vf[i]);
      end
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      n_cmp++;
      if ({out_valid, in_ready, Diff} !== {1'b0, 1'b1, vd[i]}) begin
        n_err++; $display("FAIL arith%0d_release: got ov=%b rdy=%b diff=%h want ov=0 rdy=1 diff=%h",
                          i, out_valid, in_ready, Diff, vd[i]);
      end
    end
  endtask

  task automatic test_backpressure();
    A = 16'h9000; B = 16'h1000; Bin = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
    step(); step(); step();
    n_cmp++;
    if ({out_valid, Diff, Bout, Z, N, V} !== {1'b1, 16'h8000, 4'b0010}) begin
      n_err++; $display("FAIL bp_result: got ov=%b diff=%h bznv=%b%b%b%b want ov=1 diff=8000 bznv=0010",
                        out_valid, Diff, Bout, Z, N, V);
    end
    for (int c = 0; c < 5; c++) begin
      A = 16'h0011 * 16'(c + 1); B = 16'h0101 * 16'(c + 2); Bin = c[0];
      step();
      n_cmp++;
      if ({out_valid, in_ready, Diff} !== {1'b1, 1'b0, 16'h8000}) begin
        n_err++; $display("FAIL bp_hold%0d: got ov=%b rdy=%b diff=%h want ov=1 rdy=0 diff=8000",
                          c, out_valid, in_ready, Diff);
      end
    end
    in_valid = 1'b0; out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    n_cmp++;
    if ({out_valid, in_ready, Diff} !== {1'b0, 1'b1, 16'h8000}) begin
      n_err++; $display("FAIL bp_release: got ov=%b rdy=%b diff=%h want ov=0 rdy=1 diff=8000",
                        out_valid, in_ready, Diff);
    end
    step(); step(); step();
    n_cmp++;
    if ({out_valid, in_ready} !== 2'b01) begin
      n_err++; $display("FAIL bp_no_accept: got ov=%b rdy=%b want ov=0 rdy=1", out_valid, in_ready);
    end
  endtask

  task automatic test_back_to_back();
    A = 16'h000A; B = 16'h0003; Bin = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    step();                                  // accept, out_ready idle-high has no effect
    A = 16'h0020; B = 16'h0001;
    n_cmp++;
    if ({in_ready, out_valid} !== 2'b00) begin
      n_err++; $display("FAIL b2b_busy: got rdy=%b ov=%b want 00", in_ready, out_valid);
    end
    step(); step();
    n_cmp++;
    if ({out_valid, Diff} !== {1'b1, 16'h0007}) begin
      n_err++; $display("FAIL b2b_first: got ov=%b diff=%h want ov=1 diff=0007", out_valid, Diff);
    end
    step();                                  // consumed, back to IDLE
    n_cmp++;
    if ({out_valid, in_ready, Diff} !== {1'b0, 1'b1, 16'h0007}) begin
      n_err++; $display("FAIL b2b_gap: got ov=%b rdy=%b diff=%h want ov=0 rdy=1 diff=0007", out_valid, in_ready, Diff);
    end
    step();                                  // second accept
    in_valid = 1'b0;
    step(); step();
    n_cmp++;
    if ({out_valid, Diff, Bout} !== {1'b1, 16'h001F, 1'b0}) begin
      n_err++; $display("FAIL b2b_second: got ov=%b diff=%h bout=%b want ov=1 diff=001f bout=0", out_valid, Diff, Bout);
    end
    step();
    out_ready = 1'b0;
  endtask

  task automatic test_abort();
    A = 16'hFFFF; B = 16'h0001; Bin = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
    step();                                  // LO
    in_valid = 1'b0;
    step();                                  // HI
    rst_n = 1'b0;
    step();
    n_cmp++;
    if ({out_valid, Diff, Bout, Z, N, V, in_ready} !== 22'd0) begin
      n_err++; $display("FAIL abort_outputs: got ov=%b diff=%h flags=%b%b%b%b rdy=%b want all 0",
                        out_valid, Diff, Bout, Z, N, V, in_ready);
    end
    rst_n = 1'b1;
    #1;
    n_cmp++;
    if (in_ready !== 1'b1) begin n_err++; $display("FAIL abort_ready: got %b want 1", in_ready); end
    step(); step();
    n_cmp++;
    if (out_valid !== 1'b0) begin n_err++; $display("FAIL abort_no_result: got ov=%b want 0", out_valid); end
    A = 16'h0003; B = 16'h0001; Bin = 1'b0; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step(); step();
    n_cmp++;
    if ({out_valid, Diff, Bout, Z, N, V} !== {1'b1, 16'h0002, 4'b0000}) begin
      n_err++; $display("FAIL abort_next_op: got ov=%b diff=%h bznv=%b%b%b%b want ov=1 diff=0002 bznv=0000",
                        out_valid, Diff, Bout, Z, N, V);
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  initial begin
    #1;
    test_reset();
    test_arith();
    test_backpressure();
    test_back_to_back();
    test_abort();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/sixteen_bit_seq_subtractor.md
SIXTEEN_BIT_SEQ_SUBTRACTOR -- requirements
Module: sixteen_bit_seq_subtractor

Interface
REQ-001: The block SHALL have no parameters; all widths are fixed (16-bit operands, 8-bit slice).
REQ-002: clk  input  1  single clock; all state changes on rising edge.
REQ-003: rst_n  input  1  reset, synchronous, active-low; one clock, and reset is synchronous and active-low.
REQ-004: in_valid  input  1  operand set on A/B/Bin is valid.
REQ-005: in_ready  output  1  block can accept operands; equals (state==IDLE) AND rst_n.
REQ-006: A  input  16  minuend, unsigned/two's-complement.
REQ-007: B  input  16  subtrahend.
REQ-008: Bin  input  1  borrow-in.
REQ-009: out_valid  output  1  Diff and flags hold a completed result.
REQ-010: out_ready  input  1  consumer accepts result.
REQ-011: Diff  output  16  (A - B - Bin) mod 2^16.
REQ-012: Bout  output  1  borrow-out; 1 iff unsigned A < B + Bin.
REQ-013: Z  output  1  Diff == 0x0000.
REQ-014: N  output  1  Diff[15].
REQ-015: V  output  1  signed overflow: A[15] != B[15] and Diff[15] != A[15].

Function
REQ-016: The FSM SHALL have states IDLE, LO, HI, DONE, encoded in a registered state variable.
REQ-017: IDLE: when in_valid=1, SHALL register A, B, Bin and go to LO; otherwise stay IDLE.
REQ-018: LO: SHALL compute low byte Ah[7:0]-Bh[7:0]-Bin, register Diff[7:0] and internal borrow, go to HI unconditionally.
REQ-019: HI: SHALL compute high byte A[15:8]-B[15:8]-borrow, register Diff[15:8], Bout, Z, N, V, set out_valid=1, go to DONE.
REQ-020: DONE: SHALL hold out_valid=1 and all result outputs stable; on out_ready=1 clear out_valid and go to IDLE.
REQ-021: Latency: operands accepted at edge k SHALL produce out_valid=1 from edge k+2 onward.
REQ-022: Throughput SHALL be at most one operation per 4 cycles; no acceptance in LO, HI, DONE.
REQ-023: in_valid asserted while in_ready=0 SHALL be ignored; operand inputs need only be stable at the accepting edge.
REQ-024: Operand changes on A/B/Bin after acceptance SHALL NOT affect the in-flight result.
REQ-025: Diff/Bout/Z/N/V SHALL retain last completed result after DONE->IDLE until next HI edge; Diff[7:0] may update at LO edge and is only meaningful while out_valid=1.
REQ-026: out_ready asserted while out_valid=0 SHALL have no effect.
REQ-027: Borrow chain SHALL be exact across the byte boundary, including Bin=1 with A[7:0]=B[7:0].

Reset
REQ-028: While rst_n=0 at a rising edge: state SHALL become IDLE; out_valid, Diff, Bout, Z, N, V SHALL become 0; internal operand and borrow registers SHALL clear.
REQ-029: in_ready SHALL be 0 while rst_n=0 and 1 in the first cycle after rst_n returns high.
REQ-030: Reset in any state (LO, HI, DONE) SHALL abort the operation; no result SHALL be emitted for it.

Verification
REQ-031: A=0x1234, B=0x0234, Bin=0 -> Diff=0x1000, Bout=0, Z=0, N=0, V=0; out_valid high exactly 2 edges after accept.
REQ-032: A=0x0000, B=0x0001, Bin=0 -> Diff=0xFFFF, Bout=1, N=1, V=0, Z=0.
REQ-033: A=0x8000, B=0x0001, Bin=0 -> Diff=0x7FFF, V=1, N=0, Bout=0; A=0x0100, B=0x0001, Bin=1 -> Diff=0x00FE, Bout=0 (cross-byte borrow).
REQ-034: A=0x5555, B=0x5554, Bin=1 -> Diff=0x0000, Z=1, Bout=0; A=0x0000, B=0xFFFF, Bin=1 -> Diff=0x0000, Z=1, Bout=1.
REQ-035: Backpressure: hold out_ready=0 for 5 cycles after out_valid with in_valid=1 and changing A/B -> out_valid and Diff stable, in_ready=0, no new accept; out_ready=1 -> IDLE next edge, in_ready=1.
REQ-036: Assert rst_n=0 for one edge while in HI -> next cycle out_valid=0, all outputs 0, in_ready=1 after release; subsequent op A=0x0003, B=0x0001 -> Diff=0x0002.
